// File: rtl/clk_divider_multi_pkg.sv
// Shared constants and bus-slicing helper for the multi-channel clock divider.
// Defaults give a 1 Hz output from a 100 MHz system clock.
package clk_divider_multi_pkg;

  localparam int CNT_W_DEF = 28;
  localparam logic [CNT_W_DEF-1:0] RST_DIV_DEF  = 28'd100_000000;
  localparam logic [CNT_W_DEF-1:0] RST_HIGH_DEF = 28'd0;
  localparam int DIV_MIN = 2;

  // Low bit index of channel idx inside a packed per-channel bus.
  function automatic int field_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: shadow/active config, clamp, period counter and output registers.
// The shadow config is applied only at a period boundary, so no period is ever cut or stretched.
module clk_div_channel
  import clk_divider_multi_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV  = CNT_W'(RST_DIV_DEF),
  parameter logic [CNT_W-1:0] RST_HIGH = CNT_W'(RST_HIGH_DEF)
) (
  input  logic             sys_clk_in,
  input  logic             reset,
  input  logic             ch_en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             phase_sync,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(DIV_MIN);

  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] sh_div;
  logic [CNT_W-1:0] sh_high;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_e;
  logic [CNT_W-1:0] high_raw;
  logic [CNT_W-1:0] high_e;
  logic             wrap;
  logic             apply;

  // High time is forced into [1, div_e-1] so the output always toggles.
  always_comb begin
    div_e    = (act_div < MIN_DIV) ? MIN_DIV : act_div;
    high_raw = (act_high == '0) ? (div_e >> 1) : act_high;
    high_e   = high_raw;
    if (high_raw < ONE) begin
      high_e = ONE;
    end else if (high_raw > (div_e - ONE)) begin
      high_e = div_e - ONE;
    end
    wrap  = (count >= div_e);
    apply = !ch_en || phase_sync || wrap;
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      act_div     <= RST_DIV;
      act_high    <= RST_HIGH;
      sh_div      <= RST_DIV;
      sh_high     <= RST_HIGH;
      count       <= ONE;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      if (apply) begin
        count <= ONE;
      end else begin
        count <= count + ONE;
      end
      clk_out <= ch_en && (count <= high_e);
      tick    <= ch_en && (count == ONE);
      if (apply && cfg_pending) begin
        act_div  <= sh_div;
        act_high <= sh_high;
      end
      // A load on the boundary edge stays pending; the boundary used the older shadow.
      if (cfg_load) begin
        sh_div      <= cfg_div;
        sh_high     <= cfg_high;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/strobe generator.
// Replicates clk_div_channel and slices the packed configuration buses.
module clk_divider_multi
  import clk_divider_multi_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV  = CNT_W'(RST_DIV_DEF),
  parameter logic [CNT_W-1:0] RST_HIGH = CNT_W'(RST_HIGH_DEF)
) (
  input  logic                    sys_clk_in,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] cfg_div,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  input  logic                    phase_sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W    (CNT_W),
      .RST_DIV  (RST_DIV),
      .RST_HIGH (RST_HIGH)
    ) u_ch (
      .sys_clk_in  (sys_clk_in),
      .reset       (reset),
      .ch_en       (ch_en[i]),
      .cfg_load    (cfg_load[i]),
      .cfg_div     (cfg_div[field_lo(i, CNT_W) +: CNT_W]),
      .cfg_high    (cfg_high[field_lo(i, CNT_W) +: CNT_W]),
      .phase_sync  (phase_sync),
      .clk_out     (clk_out[i]),
      .tick        (tick[i]),
      .cfg_pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios with literal waveforms,
// then randomized traffic, all compared every cycle against a period-queue reference model.
module tb_clk_divider_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 28;
  localparam int RDIV   = 6;

  logic                    sys_clk_in = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       cfg_load;
  logic [NUM_CH*CNT_W-1:0] cfg_div;
  logic [NUM_CH*CNT_W-1:0] cfg_high;
  logic                    phase_sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       cfg_pending;

  int checks = 0;
  int passes = 0;

  logic [15:0] clk_hist  [NUM_CH];
  logic [15:0] tick_hist [NUM_CH];
  logic [15:0] pend_hist [NUM_CH];

  clk_divider_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .RST_DIV  (28'd6),
    .RST_HIGH (28'd0)
  ) dut (
    .sys_clk_in  (sys_clk_in),
    .reset       (reset),
    .ch_en       (ch_en),
    .cfg_load    (cfg_load),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .phase_sync  (phase_sync),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  always #5 sys_clk_in = ~sys_clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each running channel replays a precomputed waveform of one whole period.
  // When a period's waveform is used up (or phase_sync hits), pending config becomes active.
  logic [1:0] mq [NUM_CH][$];
  int m_div [NUM_CH];
  int m_high[NUM_CH];
  int s_div [NUM_CH];
  int s_high[NUM_CH];
  bit m_pend[NUM_CH];
  logic [NUM_CH-1:0] exp_clk  = '0;
  logic [NUM_CH-1:0] exp_tick = '0;
  logic [NUM_CH-1:0] exp_pend = '0;

  function automatic void effective(input int d, input int h, output int de, output int he);
    de = (d < 2) ? 2 : d;
    he = (h == 0) ? de / 2 : h;
    if (he > de - 1) he = de - 1;
    if (he < 1) he = 1;
  endfunction

  always @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_div[c]  = RDIV;
        m_high[c] = 0;
        s_div[c]  = RDIV;
        s_high[c] = 0;
        m_pend[c] = 1'b0;
        mq[c].delete();
      end
      exp_clk  = '0;
      exp_tick = '0;
      exp_pend = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic [1:0] v;
        int de;
        int he;
        v = 2'b00;
        if (ch_en[c]) begin
          if (mq[c].size() == 0) begin
            effective(m_div[c], m_high[c], de, he);
            for (int j = 0; j < de; j++) mq[c].push_back({(j < he), (j == 0)});
          end
          v = mq[c].pop_front();
          if (mq[c].size() == 0 || phase_sync) begin
            mq[c].delete();
            if (m_pend[c]) begin
              m_div[c]  = s_div[c];
              m_high[c] = s_high[c];
              m_pend[c] = 1'b0;
            end
          end
        end else begin
          mq[c].delete();
          if (m_pend[c]) begin
            m_div[c]  = s_div[c];
            m_high[c] = s_high[c];
            m_pend[c] = 1'b0;
          end
        end
        if (cfg_load[c]) begin
          s_div[c]  = int'(cfg_div[c*CNT_W +: CNT_W]);
          s_high[c] = int'(cfg_high[c*CNT_W +: CNT_W]);
          m_pend[c] = 1'b1;
        end
        exp_clk[c]  = v[1];
        exp_tick[c] = v[0];
        exp_pend[c] = m_pend[c];
      end
    end
  end

  always @(negedge sys_clk_in) begin
    for (int c = 0; c < NUM_CH; c++) begin
      checkOutput($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(exp_clk[c]));
      checkOutput($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(exp_tick[c]));
      checkOutput($sformatf("cfg_pending[%0d]", c), 32'(cfg_pending[c]), 32'(exp_pend[c]));
    end
  end

  task automatic setCfg(input int c, input int div, input int high);
    cfg_div[c*CNT_W +: CNT_W]  = CNT_W'(div);
    cfg_high[c*CNT_W +: CNT_W] = CNT_W'(high);
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] load,
                               input logic sync);
    ch_en      = en;
    cfg_load   = load;
    phase_sync = sync;
  endtask

  task automatic captureCycles(input int n);
    repeat (n) begin
      @(negedge sys_clk_in);
      for (int c = 0; c < NUM_CH; c++) begin
        clk_hist[c]  = {clk_hist[c][14:0], clk_out[c]};
        tick_hist[c] = {tick_hist[c][14:0], tick[c]};
        pend_hist[c] = {pend_hist[c][14:0], cfg_pending[c]};
      end
    end
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    cfg_div  = '0;
    cfg_high = '0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge sys_clk_in);
    checkOutput("reset_clk_out", 32'(clk_out), 32'd0);
    checkOutput("reset_tick", 32'(tick), 32'd0);
    checkOutput("reset_pending", 32'(cfg_pending), 32'd0);
    reset = 1'b1;

    // Scenario 1: ch0 div=4 auto high
    setCfg(0, 4, 0);
    applyStimulus(4'b0000, 4'b0001, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    captureCycles(1);
    checkOutput("t1_pend_disabled", 32'(pend_hist[0][1:0]), 32'(2'b10));
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    captureCycles(8);
    checkOutput("t1_clk0", 32'(clk_hist[0][7:0]), 32'(8'b11001100));
    checkOutput("t1_tick0", 32'(tick_hist[0][7:0]), 32'(8'b10001000));

    // Scenario 2: ch1 div=5 high=2, ch2 div=0 clamps to 2
    setCfg(1, 5, 2);
    setCfg(2, 0, 0);
    applyStimulus(4'b0001, 4'b0110, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    captureCycles(10);
    checkOutput("t2_clk1", 32'(clk_hist[1][9:0]), 32'(10'b1100011000));
    checkOutput("t2_tick1", 32'(tick_hist[1][9:0]), 32'(10'b1000010000));
    checkOutput("t2_clk2", 32'(clk_hist[2][9:0]), 32'(10'b1010101010));
    checkOutput("t2_tick2", 32'(tick_hist[2][9:0]), 32'(10'b1010101010));

    // Scenario 3: div=8 running, load div=3 high=2 at count 2
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    setCfg(0, 8, 0);
    applyStimulus(4'b0110, 4'b0001, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    captureCycles(1);
    setCfg(0, 3, 2);
    applyStimulus(4'b0111, 4'b0001, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    captureCycles(12);
    checkOutput("t3_clk0", 32'(clk_hist[0][13:0]), 32'(14'b11110000_110110));
    checkOutput("t3_tick0", 32'(tick_hist[0][13:0]), 32'(14'b10000000_100100));
    checkOutput("t3_pend0", 32'(pend_hist[0][13:0]), 32'(14'b01111110_000000));

    // Scenario 4: two loads in one period, only the second applies
    applyStimulus(4'b0111, 4'b0000, 1'b1);
    captureCycles(1);
    setCfg(0, 6, 0);
    applyStimulus(4'b0111, 4'b0001, 1'b0);
    captureCycles(1);
    setCfg(0, 10, 0);
    applyStimulus(4'b0111, 4'b0001, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    captureCycles(11);
    checkOutput("t4_clk0", 32'(clk_hist[0][12:0]), 32'(13'b110_1111100000));
    checkOutput("t4_tick0", 32'(tick_hist[0][12:0]), 32'(13'b100_1000000000));

    // Scenario 5: ch0 div=4, ch1 div=6, then phase_sync
    setCfg(0, 4, 0);
    setCfg(1, 6, 0);
    applyStimulus(4'b0111, 4'b0011, 1'b0);
    captureCycles(1);
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    captureCycles(24);
    applyStimulus(4'b0111, 4'b0000, 1'b1);
    captureCycles(1);
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    captureCycles(13);
    checkOutput("t5_tick0", 32'(tick_hist[0][12:0]), 32'(13'b1000100010001));
    checkOutput("t5_tick1", 32'(tick_hist[1][12:0]), 32'(13'b1000001000001));

    // Scenario 6: reset during a high phase of ch0
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge sys_clk_in);
      if (clk_out[0]) found = 1'b1;
    end
    checkOutput("t6_wait_high", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_async_clk", 32'(clk_out), 32'd0);
    checkOutput("t6_async_tick", 32'(tick), 32'd0);
    checkOutput("t6_async_pend", 32'(cfg_pending), 32'd0);
    @(negedge sys_clk_in);
    reset = 1'b1;
    captureCycles(7);
    checkOutput("t6_clk0", 32'(clk_hist[0][6:0]), 32'(7'b1110001));
    checkOutput("t6_tick0", 32'(tick_hist[0][6:0]), 32'(7'b1000001));

    // Randomized traffic with one mid-run reset
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NUM_CH-1:0] en;
      logic [NUM_CH-1:0] ld;
      en = ch_en;
      ld = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 31) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 7) == 0) begin
          ld[c] = 1'b1;
          setCfg(c, int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
        end
      end
      applyStimulus(en, ld, ($urandom_range(0, 31) == 0));
      if (cyc == 1500) begin
        #3 reset = 1'b0;
        @(negedge sys_clk_in);
        reset = 1'b1;
      end else begin
        @(negedge sys_clk_in);
      end
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
